// File: rtl/cluster_periph_demux.sv
// N-master x M-slave peripheral request demux with per-slave round-robin arbitration,
// ID-routed responses and local error responses for unmapped slots. Optional stall counters: CLUSTER_PERIPH_DEMUX_PERF_EN.
module cluster_periph_demux #(
    parameter int unsigned       NB_MASTERS = 9,
    parameter int unsigned       NB_SLAVES  = 11,
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       SLOT_LSB   = 10,
    parameter logic [DATA_W-1:0] ERR_RDATA  = 32'hBADACCE5,
    localparam int unsigned      BE_W       = DATA_W / 8,
    localparam int unsigned      SEL_W      = (NB_SLAVES > 1) ? $clog2(NB_SLAVES) : 1,
    localparam int unsigned      ID_W       = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NB_MASTERS-1:0]        m_req_i,
    input  logic [NB_MASTERS*ADDR_W-1:0] m_add_i,
    input  logic [NB_MASTERS-1:0]        m_wen_i,
    input  logic [NB_MASTERS*BE_W-1:0]   m_be_i,
    input  logic [NB_MASTERS*DATA_W-1:0] m_wdata_i,
    output logic [NB_MASTERS-1:0]        m_gnt_o,
    output logic [NB_MASTERS-1:0]        m_r_valid_o,
    output logic [NB_MASTERS*DATA_W-1:0] m_r_rdata_o,
    output logic [NB_MASTERS-1:0]        m_r_opc_o,
    output logic [NB_SLAVES-1:0]         s_req_o,
    output logic [NB_SLAVES*ADDR_W-1:0]  s_add_o,
    output logic [NB_SLAVES-1:0]         s_wen_o,
    output logic [NB_SLAVES*BE_W-1:0]    s_be_o,
    output logic [NB_SLAVES*DATA_W-1:0]  s_wdata_o,
    output logic [NB_SLAVES*ID_W-1:0]    s_id_o,
    input  logic [NB_SLAVES-1:0]         s_gnt_i,
    input  logic [NB_SLAVES-1:0]         s_r_valid_i,
    input  logic [NB_SLAVES*DATA_W-1:0]  s_r_rdata_i,
    input  logic [NB_SLAVES-1:0]         s_r_opc_i,
    input  logic [NB_SLAVES*ID_W-1:0]    s_r_id_i
`ifdef CLUSTER_PERIPH_DEMUX_PERF_EN
    ,
    output logic [NB_MASTERS*16-1:0]     perf_stall_o
`endif
);

    logic [SEL_W-1:0]      sel [NB_MASTERS];
    logic [NB_MASTERS-1:0] mapped;
    logic [NB_MASTERS-1:0] unmapped;
    logic [ID_W-1:0]       rr  [NB_SLAVES];
    logic [ID_W-1:0]       win [NB_SLAVES];
    logic [NB_SLAVES-1:0]  found;
    logic [NB_MASTERS-1:0] gnt_map;
    logic [NB_MASTERS-1:0] err_pend;
    logic [NB_MASTERS-1:0] slv_hit;

    always_comb begin
        mapped   = '0;
        unmapped = '0;
        for (int unsigned m = 0; m < NB_MASTERS; m++) begin
            sel[m]      = m_add_i[m*ADDR_W + SLOT_LSB +: SEL_W];
            mapped[m]   = m_req_i[m] & (32'(sel[m]) < NB_SLAVES);
            unmapped[m] = m_req_i[m] & ~mapped[m];
        end
    end

    // Scan masters starting at the priority pointer; first hit wins.
    always_comb begin
        found     = '0;
        gnt_map   = '0;
        s_req_o   = '0;
        s_add_o   = '0;
        s_wen_o   = '0;
        s_be_o    = '0;
        s_wdata_o = '0;
        s_id_o    = '0;
        for (int unsigned s = 0; s < NB_SLAVES; s++) begin
            win[s] = '0;
            for (int unsigned i = 0; i < NB_MASTERS; i++) begin
                int unsigned idx;
                idx = 32'(rr[s]) + i;
                if (idx >= NB_MASTERS) idx = idx - NB_MASTERS;
                if (!found[s] && mapped[idx] && (32'(sel[idx]) == s)) begin
                    found[s] = 1'b1;
                    win[s]   = ID_W'(idx);
                end
            end
            s_req_o[s]                   = found[s] & ~rst_i;
            s_add_o[s*ADDR_W +: ADDR_W]  = m_add_i[32'(win[s])*ADDR_W +: ADDR_W];
            s_wen_o[s]                   = m_wen_i[win[s]];
            s_be_o[s*BE_W +: BE_W]       = m_be_i[32'(win[s])*BE_W +: BE_W];
            s_wdata_o[s*DATA_W +: DATA_W] = m_wdata_i[32'(win[s])*DATA_W +: DATA_W];
            s_id_o[s*ID_W +: ID_W]       = win[s];
            if (found[s] && s_gnt_i[s] && !rst_i) gnt_map[win[s]] = 1'b1;
        end
    end

    always_comb begin
        m_gnt_o = '0;
        if (!rst_i) m_gnt_o = gnt_map | (unmapped & ~err_pend);
    end

    // A slave response always takes precedence over a pending local error.
    always_comb begin
        slv_hit     = '0;
        m_r_valid_o = '0;
        m_r_opc_o   = '0;
        m_r_rdata_o = '0;
        for (int unsigned m = 0; m < NB_MASTERS; m++) begin
            for (int unsigned s = 0; s < NB_SLAVES; s++) begin
                if (s_r_valid_i[s] && (s_r_id_i[s*ID_W +: ID_W] == ID_W'(m))) begin
                    slv_hit[m] = 1'b1;
                    m_r_rdata_o[m*DATA_W +: DATA_W] |= s_r_rdata_i[s*DATA_W +: DATA_W];
                    m_r_opc_o[m] |= s_r_opc_i[s];
                end
            end
            if (!slv_hit[m] && err_pend[m]) begin
                m_r_rdata_o[m*DATA_W +: DATA_W] = ERR_RDATA;
                m_r_opc_o[m]                    = 1'b1;
            end
            m_r_valid_o[m] = slv_hit[m] | err_pend[m];
        end
        if (rst_i) begin
            m_r_valid_o = '0;
            m_r_opc_o   = '0;
            m_r_rdata_o = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned s = 0; s < NB_SLAVES; s++) rr[s] <= '0;
            err_pend <= '0;
        end else begin
            for (int unsigned s = 0; s < NB_SLAVES; s++) begin
                if (s_req_o[s] && s_gnt_i[s])
                    rr[s] <= (32'(win[s]) + 1 == NB_MASTERS) ? '0 : win[s] + 1'b1;
            end
            err_pend <= (err_pend & slv_hit) | (unmapped & ~err_pend);
        end
    end

`ifdef CLUSTER_PERIPH_DEMUX_PERF_EN
    logic [15:0] stall_cnt [NB_MASTERS];

    always_ff @(posedge clk_i) begin
        for (int unsigned m = 0; m < NB_MASTERS; m++) begin
            if (rst_i)
                stall_cnt[m] <= '0;
            else if (m_req_i[m] && !m_gnt_o[m] && (stall_cnt[m] != '1))
                stall_cnt[m] <= stall_cnt[m] + 16'd1;
        end
    end

    always_comb begin
        perf_stall_o = '0;
        for (int unsigned m = 0; m < NB_MASTERS; m++) perf_stall_o[m*16 +: 16] = stall_cnt[m];
    end
`endif

endmodule

// File: tb/tb_cluster_periph_demux.sv
// Self-checking bench for cluster_periph_demux: directed vector table, hand sequences,
// then randomized traffic against a behavioural model.
module tb_cluster_periph_demux;

    localparam int NBM = 9;
    localparam int NBS = 11;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = 4;
    localparam int IW  = 4;
    localparam int SLOT_LSB = 10;
    localparam logic [31:0] ERR = 32'hBADACCE5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NBM-1:0]    m_req, m_wen, m_gnt, m_r_valid, m_r_opc;
    logic [NBM*AW-1:0] m_add;
    logic [NBM*BW-1:0] m_be;
    logic [NBM*DW-1:0] m_wdata, m_r_rdata;
    logic [NBS-1:0]    s_req, s_wen, s_gnt, s_r_valid, s_r_opc;
    logic [NBS*AW-1:0] s_add;
    logic [NBS*BW-1:0] s_be;
    logic [NBS*DW-1:0] s_wdata, s_r_rdata;
    logic [NBS*IW-1:0] s_id, s_r_id;
`ifdef CLUSTER_PERIPH_DEMUX_PERF_EN
    logic [NBM*16-1:0] perf_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cluster_periph_demux #(.NB_MASTERS(NBM), .NB_SLAVES(NBS), .ADDR_W(AW), .DATA_W(DW),
                           .SLOT_LSB(SLOT_LSB), .ERR_RDATA(ERR)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_req_i(m_req), .m_add_i(m_add), .m_wen_i(m_wen), .m_be_i(m_be), .m_wdata_i(m_wdata),
        .m_gnt_o(m_gnt), .m_r_valid_o(m_r_valid), .m_r_rdata_o(m_r_rdata), .m_r_opc_o(m_r_opc),
        .s_req_o(s_req), .s_add_o(s_add), .s_wen_o(s_wen), .s_be_o(s_be), .s_wdata_o(s_wdata),
        .s_id_o(s_id), .s_gnt_i(s_gnt), .s_r_valid_i(s_r_valid), .s_r_rdata_i(s_r_rdata),
        .s_r_opc_i(s_r_opc), .s_r_id_i(s_r_id)
`ifdef CLUSTER_PERIPH_DEMUX_PERF_EN
        , .perf_stall_o(perf_stall)
`endif
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural reference model state
    int          rr_m   [NBS];
    bit          errp_m [NBM];
    int          stall_m[NBM];
    logic [NBM-1:0]    e_gnt, e_rvalid, e_ropc;
    logic [NBM*DW-1:0] e_rdata;
    logic [NBS-1:0]    e_sreq;
    int          e_win [NBS];
    bit          e_hit [NBM];
    bit          e_unm [NBM];

    function automatic int slot_of(input int m);
        logic [31:0] a;
        a = m_add[m*AW +: AW];
        return int'(a[SLOT_LSB +: 4]);
    endfunction

    task automatic model_eval();
        e_gnt = '0; e_rvalid = '0; e_ropc = '0; e_rdata = '0; e_sreq = '0;
        for (int s = 0; s < NBS; s++) begin
            int best, bestd;
            best = -1; bestd = NBM;
            for (int m = 0; m < NBM; m++) begin
                if (m_req[m] && slot_of(m) == s && ((m - rr_m[s] + NBM) % NBM) < bestd) begin
                    bestd = (m - rr_m[s] + NBM) % NBM;
                    best  = m;
                end
            end
            e_win[s] = best;
            if (best >= 0 && !rst) begin
                e_sreq[s] = 1'b1;
                if (s_gnt[s]) e_gnt[best] = 1'b1;
            end
        end
        for (int m = 0; m < NBM; m++) begin
            e_unm[m] = m_req[m] && slot_of(m) >= NBS;
            if (e_unm[m] && !errp_m[m] && !rst) e_gnt[m] = 1'b1;
            e_hit[m] = 1'b0;
            for (int s = 0; s < NBS; s++) begin
                if (s_r_valid[s] && int'(s_r_id[s*IW +: IW]) == m) begin
                    e_hit[m] = 1'b1;
                    e_rdata[m*DW +: DW] = s_r_rdata[s*DW +: DW];
                    e_ropc[m] = s_r_opc[s];
                end
            end
            if (!e_hit[m] && errp_m[m]) begin
                e_rdata[m*DW +: DW] = ERR;
                e_ropc[m] = 1'b1;
            end
            e_rvalid[m] = e_hit[m] || errp_m[m];
            if (rst) begin
                e_rvalid[m] = 1'b0; e_ropc[m] = 1'b0; e_rdata[m*DW +: DW] = '0;
            end
        end
    endtask

    task automatic model_update();
        for (int s = 0; s < NBS; s++)
            if (rst) rr_m[s] = 0;
            else if (e_sreq[s] && s_gnt[s]) rr_m[s] = (e_win[s] + 1) % NBM;
        for (int m = 0; m < NBM; m++) begin
            if (rst) begin
                errp_m[m] = 1'b0; stall_m[m] = 0;
            end else begin
                if (m_req[m] && !e_gnt[m] && stall_m[m] < 65535) stall_m[m]++;
                errp_m[m] = (errp_m[m] && e_hit[m]) || (e_unm[m] && !errp_m[m]);
            end
        end
    endtask

    task automatic finish_cycle();
        model_eval();
        model_update();
        @(negedge clk);
    endtask

    task automatic model_check();
        model_eval();
        chk("gnt", m_gnt, e_gnt);
        chk("s_req", s_req, e_sreq);
        chk("r_valid", m_r_valid, e_rvalid);
        chk("r_opc", m_r_opc, e_ropc);
        chk("r_rdata", m_r_rdata, e_rdata);
        for (int s = 0; s < NBS; s++) begin
            if (e_sreq[s]) begin
                int w;
                w = e_win[s];
                chk("s_fields",
                    {s_id[s*IW +: IW], s_add[s*AW +: AW], s_wen[s], s_be[s*BW +: BW], s_wdata[s*DW +: DW]},
                    {4'(w), m_add[w*AW +: AW], m_wen[w], m_be[w*BW +: BW], m_wdata[w*DW +: DW]});
            end
        end
    endtask

    task automatic idle_inputs();
        m_req = '0; m_add = '0; m_wen = '1; m_be = '1; m_wdata = '0;
        s_gnt = '1; s_r_valid = '0; s_r_rdata = '0; s_r_opc = '0; s_r_id = '0;
    endtask

    typedef struct {
        logic [NBM-1:0] req;
        logic [31:0]    add;
        logic           wen;
        logic [NBS-1:0] sgnt;
        logic [NBS-1:0] rvs;
        logic [3:0]     rid;
        logic [31:0]    rd;
        logic [NBM-1:0] eg;
        logic [NBS-1:0] es;
        logic [NBM-1:0] erv;
        int             rm;
        logic [31:0]    erd;
        logic           eop;
    } vec_t;

    vec_t vecs[17];

    task automatic apply_vec(input vec_t v);
        m_req = v.req; s_gnt = v.sgnt; s_r_valid = v.rvs; s_r_opc = '0;
        for (int m = 0; m < NBM; m++) begin
            m_add[m*AW +: AW] = v.add;
            m_wen[m]          = v.wen;
            m_wdata[m*DW +: DW] = $urandom;
        end
        for (int s = 0; s < NBS; s++) begin
            s_r_id[s*IW +: IW]    = v.rid;
            s_r_rdata[s*DW +: DW] = v.rd;
        end
    endtask

    task automatic random_inputs();
        bit used [NBM];
        for (int m = 0; m < NBM; m++) begin
            logic [31:0] a;
            used[m] = 1'b0;
            a = $urandom;
            a[SLOT_LSB +: 4] = $urandom_range(0, 1) != 0 ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            m_req[m] = 1'($urandom_range(0, 1));
            m_add[m*AW +: AW] = a;
            m_wen[m] = 1'($urandom_range(0, 1));
            m_be[m*BW +: BW] = 4'($urandom);
            m_wdata[m*DW +: DW] = $urandom;
        end
        for (int s = 0; s < NBS; s++) begin
            int id;
            id = $urandom_range(0, NBM - 1);
            s_gnt[s] = $urandom_range(0, 3) != 0;
            s_r_id[s*IW +: IW] = 4'(id);
            s_r_rdata[s*DW +: DW] = $urandom;
            s_r_opc[s] = 1'($urandom_range(0, 1));
            s_r_valid[s] = 1'b0;
            if (!rst && $urandom_range(0, 2) == 0 && !used[id]) begin
                s_r_valid[s] = 1'b1;
                used[id] = 1'b1;
            end
        end
    endtask

    initial begin
        vecs[0]  = '{9'h001, 32'h0C00, 1'b1, 11'h7FF, 11'h000, 4'd0, 32'h0,    9'h001, 11'h008, 9'h000, 0, 32'h0,  1'b0};
        vecs[1]  = '{9'h000, 32'h0000, 1'b1, 11'h7FF, 11'h000, 4'd0, 32'h0,    9'h000, 11'h000, 9'h000, 0, 32'h0,  1'b0};
        vecs[2]  = '{9'h000, 32'h0000, 1'b1, 11'h7FF, 11'h008, 4'd0, 32'h1234, 9'h000, 11'h000, 9'h001, 0, 32'h1234, 1'b0};
        vecs[3]  = '{9'h007, 32'h0000, 1'b1, 11'h7FF, 11'h000, 4'd0, 32'h0,    9'h001, 11'h001, 9'h000, 0, 32'h0,  1'b0};
        vecs[4]  = '{9'h007, 32'h0000, 1'b1, 11'h7FF, 11'h000, 4'd0, 32'h0,    9'h002, 11'h001, 9'h000, 0, 32'h0,  1'b0};
        vecs[5]  = '{9'h007, 32'h0000, 1'b1, 11'h7FF, 11'h000, 4'd0, 32'h0,    9'h004, 11'h001, 9'h000, 0, 32'h0,  1'b0};
        vecs[6]  = '{9'h007, 32'h0000, 1'b1, 11'h7FF, 11'h000, 4'd0, 32'h0,    9'h001, 11'h001, 9'h000, 0, 32'h0,  1'b0};
        vecs[7]  = '{9'h007, 32'h0000, 1'b1, 11'h7FF, 11'h000, 4'd0, 32'h0,    9'h002, 11'h001, 9'h000, 0, 32'h0,  1'b0};
        vecs[8]  = '{9'h007, 32'h0000, 1'b1, 11'h7FF, 11'h000, 4'd0, 32'h0,    9'h004, 11'h001, 9'h000, 0, 32'h0,  1'b0};
        vecs[9]  = '{9'h010, 32'h3400, 1'b1, 11'h7FF, 11'h000, 4'd0, 32'h0,    9'h010, 11'h000, 9'h000, 4, 32'h0,  1'b0};
        vecs[10] = '{9'h000, 32'h0000, 1'b1, 11'h7FF, 11'h000, 4'd0, 32'h0,    9'h000, 11'h000, 9'h010, 4, ERR,    1'b1};
        vecs[11] = '{9'h000, 32'h0000, 1'b1, 11'h7FF, 11'h000, 4'd0, 32'h0,    9'h000, 11'h000, 9'h000, 4, 32'h0,  1'b0};
        vecs[12] = '{9'h004, 32'h0400, 1'b0, 11'h7FF, 11'h000, 4'd0, 32'h0,    9'h004, 11'h002, 9'h000, 2, 32'h0,  1'b0};
        vecs[13] = '{9'h004, 32'h3400, 1'b1, 11'h7FF, 11'h000, 4'd0, 32'h0,    9'h004, 11'h000, 9'h000, 2, 32'h0,  1'b0};
        vecs[14] = '{9'h004, 32'h3400, 1'b1, 11'h7FF, 11'h002, 4'd2, 32'h5A5A, 9'h000, 11'h000, 9'h004, 2, 32'h5A5A, 1'b0};
        vecs[15] = '{9'h000, 32'h0000, 1'b1, 11'h7FF, 11'h000, 4'd0, 32'h0,    9'h000, 11'h000, 9'h004, 2, ERR,    1'b1};
        vecs[16] = '{9'h000, 32'h0000, 1'b1, 11'h7FF, 11'h000, 4'd0, 32'h0,    9'h000, 11'h000, 9'h000, 2, 32'h0,  1'b0};

        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        // Outputs stay quiet while reset is held, even with live requests
        m_req = '1;
        #1;
        chk("rst_gnt", m_gnt, '0);
        chk("rst_sreq", s_req, '0);
        chk("rst_rvalid", m_r_valid, '0);
        finish_cycle();
        rst = 1'b0;
        idle_inputs();
        finish_cycle();

        for (int i = 0; i < 17; i++) begin
            apply_vec(vecs[i]);
            #1;
            chk($sformatf("vec%0d_gnt", i), m_gnt, vecs[i].eg);
            chk($sformatf("vec%0d_sreq", i), s_req, vecs[i].es);
            chk($sformatf("vec%0d_rvalid", i), m_r_valid, vecs[i].erv);
            chk($sformatf("vec%0d_rdata", i), m_r_rdata[vecs[i].rm*DW +: DW], vecs[i].erd);
            chk($sformatf("vec%0d_ropc", i), m_r_opc[vecs[i].rm], vecs[i].eop);
            finish_cycle();
        end

        // Slave 5 withholds grant for four cycles while master 7 waits
        idle_inputs();
        m_req[7] = 1'b1;
        m_add[7*AW +: AW] = 32'h1400;
        s_gnt[5] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_gnt", m_gnt, '0);
            chk("stall_sreq", s_req, 11'h020);
            chk("stall_sid", s_id[5*IW +: IW], 4'd7);
            finish_cycle();
        end
        m_req[8] = 1'b1;
        m_add[8*AW +: AW] = 32'h1400;
        s_gnt = '1;
        #1;
        chk("rr_held_gnt", m_gnt, 9'h080);
        chk("rr_held_sid", s_id[5*IW +: IW], 4'd7);
        finish_cycle();
        idle_inputs();
        #1;
`ifdef CLUSTER_PERIPH_DEMUX_PERF_EN
        chk("perf_m7", perf_stall[7*16 +: 16], 16'd4);
        chk("perf_m8", perf_stall[8*16 +: 16], 16'd1);
`endif
        finish_cycle();

        // Reset while an error response is pending
        m_req[4] = 1'b1;
        m_add[4*AW +: AW] = 32'h3400;
        #1;
        chk("pre_rst_gnt", m_gnt, 9'h010);
        finish_cycle();
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("in_rst_rvalid", m_r_valid, '0);
        finish_cycle();
        rst = 1'b0;
        #1;
        chk("post_rst_rvalid", m_r_valid, '0);
        chk("post_rst_rdata", m_r_rdata, '0);
        finish_cycle();
        m_req[1] = 1'b1;
        m_req[8] = 1'b1;
        #1;
        chk("post_rst_rr_gnt", m_gnt, 9'h002);
        chk("post_rst_rr_sid", s_id[0 +: IW], 4'd1);
        finish_cycle();

        rst = 1'b1;
        idle_inputs();
        finish_cycle();
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            random_inputs();
            #1;
            model_check();
            model_update();
            @(negedge clk);
        end
        rst = 1'b0;
        idle_inputs();
        #1;
`ifdef CLUSTER_PERIPH_DEMUX_PERF_EN
        for (int m = 0; m < NBM; m++)
            chk($sformatf("perf_rand_m%0d", m), perf_stall[m*16 +: 16], 16'(stall_m[m]));
`endif
        model_check();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
